// File: rtl/crc_link_pkg.sv
// Definitions shared by both ends of the serial CRC link: frame FSM states
// and the default frame geometry and polynomial.
package crc_link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } crc_state_e;

    localparam int         DEF_DATA_W   = 8;
    localparam int         DEF_CRC_W    = 4;
    localparam logic [3:0] DEF_POLY     = 4'h3;   // x^4 + x + 1, top term implicit
    localparam logic [3:0] DEF_CRC_INIT = 4'h0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/crc_serial_lfsr.sv
// Bit-serial CRC register: one MSB-first input bit folded in per enable.
// Both ends of the link share this so their CRCs agree by construction.
module crc_serial_lfsr #(
    parameter int               CRC_W = 4,
    parameter logic [CRC_W-1:0] POLY  = 4'h3,
    parameter logic [CRC_W-1:0] INIT  = '0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             init,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic fb;

    assign fb = crc[CRC_W-1] ^ din;

    always_ff @(posedge CLK) begin
        if (CLR || init) begin
            crc <= INIT;
        end else if (en) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/serial_crc_receiver.sv
// Receive end of the serial CRC link: start-bit detect, payload and CRC
// deserialisation, CRC check, and a valid/ready output holding register.
//
// state | meaning
// IDLE  | waiting for a sampled start bit (SIN=1 on SEN)
// DATA  | shifting in DATA_W payload bits, MSB first, CRC updated per bit
// CRC   | shifting in CRC_W received check bits, MSB first
// DONE  | one cycle: hand frame to output register or flag overrun
module serial_crc_receiver
    import crc_link_pkg::*;
#(
    parameter int               DATA_W   = DEF_DATA_W,
    parameter int               CRC_W    = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY     = CRC_W'(DEF_POLY),
    parameter logic [CRC_W-1:0] CRC_INIT = CRC_W'(DEF_CRC_INIT)
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              SEN,
    input  logic              SIN,
    output logic [DATA_W-1:0] DOUT,
    output logic              DVALID,
    input  logic              DREADY,
    output logic              CRC_ERR,
    output logic              OVERRUN,
    output logic              BUSY
);

    localparam int              CNT_W     = $clog2(max2(DATA_W, CRC_W)) + 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(CRC_W - 1);

    crc_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] payload;
    logic [CRC_W-1:0]  rx_crc;
    logic [CRC_W-1:0]  crc;
    logic              crc_init;
    logic              crc_en;

    assign crc_init = (state == IDLE) && SEN && SIN;
    assign crc_en   = (state == DATA) && SEN;

    crc_serial_lfsr #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .INIT  (CRC_INIT)
    ) u_lfsr (
        .CLK  (CLK),
        .CLR  (CLR),
        .init (crc_init),
        .en   (crc_en),
        .din  (SIN),
        .crc  (crc)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state   <= IDLE;
            cnt     <= '0;
            payload <= '0;
            rx_crc  <= '0;
            DOUT    <= '0;
            DVALID  <= 1'b0;
            CRC_ERR <= 1'b0;
            OVERRUN <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            // Accept clears the output; a DONE load below overrides this.
            if (DVALID && DREADY) begin
                DVALID <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (SEN && SIN) begin
                        state <= DATA;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                DATA: begin
                    if (SEN) begin
                        payload <= {payload[DATA_W-2:0], SIN};
                        if (cnt == LAST_DATA) begin
                            cnt   <= '0;
                            state <= CRC;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CRC: begin
                    if (SEN) begin
                        rx_crc <= {rx_crc[CRC_W-2:0], SIN};
                        if (cnt == LAST_CRC) begin
                            cnt   <= '0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!DVALID || DREADY) begin
                        DOUT    <= payload;
                        CRC_ERR <= (rx_crc != crc);
                        DVALID  <= 1'b1;
                    end else begin
                        OVERRUN <= 1'b1;
                    end
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_crc_receiver.sv
// Self-checking bench for serial_crc_receiver: directed frames plus randomized
// frames checked against a polynomial-division CRC reference.
module tb_serial_crc_receiver;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          CLR;
    logic          SEN;
    logic          SIN;
    logic          DREADY;
    logic [DW-1:0] DOUT;
    logic          DVALID;
    logic          CRC_ERR;
    logic          OVERRUN;
    logic          BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    serial_crc_receiver dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .SEN     (SEN),
        .SIN     (SIN),
        .DOUT    (DOUT),
        .DVALID  (DVALID),
        .DREADY  (DREADY),
        .CRC_ERR (CRC_ERR),
        .OVERRUN (OVERRUN),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // CRC as remainder of payload * x^4 divided by x^4+x+1 (zero initial value).
    function automatic logic [3:0] ref_crc(input logic [7:0] d);
        int m;
        m = int'(d) << 4;
        for (int i = 11; i >= 4; i--) begin
            if (m[i]) m = m ^ (32'h13 << (i - 4));
        end
        return 4'(m);
    endfunction

    task automatic send_bit(input logic b, input int gap);
        SIN = b;
        SEN = 1'b1;
        tick();
        SEN = 1'b0;
        repeat (gap) tick();
    endtask

    // Returns one cycle after the edge that sampled the last CRC bit.
    task automatic send_frame(input logic [7:0] d, input logic [3:0] c, input int gap);
        send_bit(1'b1, gap);
        for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
        for (int i = 3; i >= 1; i--) send_bit(c[i], gap);
        send_bit(c[0], 0);
        SIN = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (DVALID) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_timeout: DVALID=0 required 1", tag);
        end
    endtask

    task automatic do_reset();
        CLR = 1'b1;
        repeat (2) tick();
        CLR = 1'b0;
    endtask

    task automatic test_reset();
        CLR = 1'b1; SEN = 1'b0; SIN = 1'b0; DREADY = 1'b0;
        repeat (3) tick();
        n_cmp++; if (DOUT !== 8'h00)  begin n_bad++; $display("FAIL reset_dout: got %h required 00", DOUT); end
        n_cmp++; if (DVALID !== 1'b0) begin n_bad++; $display("FAIL reset_dvalid: got %b required 0", DVALID); end
        n_cmp++; if (CRC_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_crc_err: got %b required 0", CRC_ERR); end
        n_cmp++; if (OVERRUN !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b required 0", OVERRUN); end
        n_cmp++; if (BUSY !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b required 0", BUSY); end
        CLR = 1'b0;
        tick();
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic [3:0] c,
                               input int gap, input logic exp_err);
        bit ok;
        DREADY = 1'b1;
        send_frame(d, c, gap);
        wait_valid(tag, ok);
        if (ok) begin
            n_cmp++; if (DOUT !== d) begin n_bad++; $display("FAIL %s_dout: got %h required %h", tag, DOUT, d); end
            n_cmp++; if (CRC_ERR !== exp_err) begin n_bad++; $display("FAIL %s_crc_err: got %b required %b", tag, CRC_ERR, exp_err); end
            tick();
            n_cmp++; if (DVALID !== 1'b0) begin n_bad++; $display("FAIL %s_dvalid_drop: got %b required 0", tag, DVALID); end
        end
        repeat (2) tick();
    endtask

    task automatic test_directed();
        check_frame("good_a5", 8'hA5, 4'hB, 0, 1'b0);
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b required 0", BUSY); end
        check_frame("bad_a5", 8'hA5, 4'hA, 0, 1'b1);
        check_frame("zero_slow", 8'h00, 4'h0, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        DREADY = 1'b0;
        send_frame(8'h3C, ref_crc(8'h3C), 0);
        wait_valid("b2b_first", ok);
        repeat (2) tick();
        send_frame(8'hC3, ref_crc(8'hC3), 1);
        DREADY = 1'b1;  // accept lands on the same edge as the DONE load
        tick();
        n_cmp++; if (DVALID !== 1'b1) begin n_bad++; $display("FAIL b2b_dvalid: got %b required 1", DVALID); end
        n_cmp++; if (DOUT !== 8'hC3) begin n_bad++; $display("FAIL b2b_dout: got %h required c3", DOUT); end
        n_cmp++; if (OVERRUN !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %b required 0", OVERRUN); end
        tick();
        n_cmp++; if (DVALID !== 1'b0) begin n_bad++; $display("FAIL b2b_drop: got %b required 0", DVALID); end
        repeat (2) tick();
    endtask

    task automatic test_overrun();
        bit ok;
        do_reset();
        DREADY = 1'b0;
        send_frame(8'hA5, 4'hB, 0);
        wait_valid("ovr_first", ok);
        repeat (2) tick();
        send_frame(8'h00, 4'h0, 0);
        repeat (3) tick();
        n_cmp++; if (DOUT !== 8'hA5)   begin n_bad++; $display("FAIL ovr_dout: got %h required a5", DOUT); end
        n_cmp++; if (DVALID !== 1'b1)  begin n_bad++; $display("FAIL ovr_dvalid: got %b required 1", DVALID); end
        n_cmp++; if (CRC_ERR !== 1'b0) begin n_bad++; $display("FAIL ovr_crc_err: got %b required 0", CRC_ERR); end
        n_cmp++; if (OVERRUN !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b required 1", OVERRUN); end
        DREADY = 1'b1;
        tick();
        n_cmp++; if (DVALID !== 1'b0)  begin n_bad++; $display("FAIL ovr_accept: got %b required 0", DVALID); end
        n_cmp++; if (OVERRUN !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b required 1", OVERRUN); end
        do_reset();
        n_cmp++; if (OVERRUN !== 1'b0) begin n_bad++; $display("FAIL ovr_clr: got %b required 0", OVERRUN); end
    endtask

    task automatic test_abort();
        int nvalid;
        logic [7:0] seen;
        DREADY = 1'b1;
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL abort_busy_mid: got %b required 1", BUSY); end
        do_reset();
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL abort_busy_clr: got %b required 0", BUSY); end
        nvalid = 0;
        seen = 8'h00;
        send_frame(8'hA5, 4'hB, 0);
        for (int k = 0; k < 12; k++) begin
            if (DVALID) begin
                nvalid++;
                seen = DOUT;
                n_cmp++; if (CRC_ERR !== 1'b0) begin n_bad++; $display("FAIL abort_crc_err: got %b required 0", CRC_ERR); end
            end
            tick();
        end
        n_cmp++; if (nvalid != 1) begin n_bad++; $display("FAIL abort_valid_count: got %0d required 1", nvalid); end
        n_cmp++; if (seen !== 8'hA5) begin n_bad++; $display("FAIL abort_dout: got %h required a5", seen); end
    endtask

    task automatic test_idle_hold();
        int busy_hits;
        busy_hits = 0;
        SIN = 1'b1;
        SEN = 1'b0;
        repeat (20) begin
            tick();
            if (BUSY !== 1'b0 || DVALID !== 1'b0) busy_hits++;
        end
        SIN = 1'b0;
        repeat (3) tick();
        n_cmp++; if (busy_hits != 0) begin n_bad++; $display("FAIL idle_hold: busy/valid cycles %0d required 0", busy_hits); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL idle_hold_after: got %b required 0", BUSY); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [3:0] c;
        logic       corrupt;
        int         gap;
        for (int n = 0; n < 25; n++) begin
            d       = 8'($urandom);
            corrupt = 1'($urandom_range(0, 1));
            c       = ref_crc(d);
            if (corrupt) c = c ^ 4'($urandom_range(1, 15));
            gap     = $urandom_range(0, 2);
            check_frame("rand", d, c, gap, corrupt);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_idle_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
